// File: rtl/bus_pkg.sv
// Shared definitions for the per-port bus FIFOs: packet id field and
// the push-when-full policy encoding.
package bus_pkg;

   localparam int unsigned ID_W    = 8;
   localparam int unsigned PKT_MAX = 64;

   typedef enum logic {
      OVF_DROP_NEW    = 1'b0,
      OVF_DROP_OLDEST = 1'b1
   } ovf_policy_e;

   // Packets are passed right-aligned in PKT_MAX bits; the id is the top ID_W bits of pkt_w.
   function automatic logic [ID_W-1:0] get_id(input logic [PKT_MAX-1:0] pkt,
                                             input int unsigned pkt_w);
      return ID_W'(pkt >> (pkt_w - ID_W));
   endfunction

endpackage

// File: rtl/bus_port_fifo_if.sv
// Device/bus handshake bundle of one bus port FIFO.
interface bus_port_fifo_if #(
   parameter int pckg_sz = 16,
   parameter int depth   = 8
);
   localparam int CNT_W = $clog2(depth + 1);

   logic               push;
   logic [pckg_sz-1:0] D_push;
   logic               pop;
   logic [pckg_sz-1:0] D_pop;
   logic               pndng;
   logic               full;
   logic [CNT_W-1:0]   count;
   logic               ovf;
   logic               udf;
   logic               bad_id;
   logic               clr_flags;
   logic               ovf_sticky;
   logic               udf_sticky;

   modport slave (
      input  push, D_push, pop, clr_flags,
      output D_pop, pndng, full, count, ovf, udf, bad_id, ovf_sticky, udf_sticky
   );

   modport master (
      output push, D_push, pop, clr_flags,
      input  D_pop, pndng, full, count, ovf, udf, bad_id, ovf_sticky, udf_sticky
   );
endinterface

// File: rtl/bus_fifo_mem.sv
// Simple dual-port register array: one synchronous write port, one
// asynchronous read port. Contents are intentionally not reset.
module bus_fifo_mem #(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 8,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_waddr,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic [ADDR_W-1:0] i_raddr,
   output logic [DATA_W-1:0] o_rdata
);
   logic [DATA_W-1:0] r_mem [DEPTH];

   // Write port
   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/bus_port_fifo.sv
// Per-device source FIFO in front of the shared bus: first-word
// fall-through head, occupancy tracking, overflow/underflow/id events.
module bus_port_fifo
   import bus_pkg::*;
#(
   parameter int pckg_sz     = 16,
   parameter int depth       = 8,
   parameter int DROP_OLDEST = 1,
   parameter int drvrs       = 4
) (
   input logic            clk,
   input logic            reset,
   bus_port_fifo_if.slave bus
);
   localparam int PTR_W = $clog2(depth);
   localparam int CNT_W = $clog2(depth + 1);
   localparam ovf_policy_e POLICY = (DROP_OLDEST != 0) ? OVF_DROP_OLDEST : OVF_DROP_NEW;

   logic [PTR_W-1:0]   r_wr_ptr, r_rd_ptr;
   logic [CNT_W-1:0]   r_count;
   logic               r_ovf, r_udf, r_bad_id;
   logic               r_ovf_sticky, r_udf_sticky;

   logic               w_empty, w_full;
   logic               w_wr_en, w_rd_adv;
   logic               w_ovf, w_udf, w_bad_id;
   logic [CNT_W-1:0]   w_count_nxt;
   logic [pckg_sz-1:0] w_rd_data;

   assign w_empty = (r_count == {CNT_W{1'b0}});
   assign w_full  = (r_count == CNT_W'(depth));

   // Per-edge push/pop decision; an empty FIFO never bypasses push data to pop.
   always_comb begin
      w_wr_en     = 1'b0;
      w_rd_adv    = 1'b0;
      w_ovf       = 1'b0;
      w_udf       = 1'b0;
      w_count_nxt = r_count;
      case ({bus.push, bus.pop})
         2'b10: begin
            if (!w_full) begin
               w_wr_en     = 1'b1;
               w_count_nxt = r_count + CNT_W'(1);
            end else if (POLICY == OVF_DROP_OLDEST) begin
               w_wr_en  = 1'b1;
               w_rd_adv = 1'b1;
               w_ovf    = 1'b1;
            end else begin
               w_ovf = 1'b1;
            end
         end
         2'b01: begin
            if (!w_empty) begin
               w_rd_adv    = 1'b1;
               w_count_nxt = r_count - CNT_W'(1);
            end else begin
               w_udf = 1'b1;
            end
         end
         2'b11: begin
            if (!w_empty) begin
               w_wr_en  = 1'b1;
               w_rd_adv = 1'b1;
            end else begin
               w_wr_en     = 1'b1;
               w_udf       = 1'b1;
               w_count_nxt = r_count + CNT_W'(1);
            end
         end
         default: begin
            w_wr_en = 1'b0;
         end
      endcase
   end

   assign w_bad_id = w_wr_en &&
                     (32'(get_id(PKT_MAX'(bus.D_push), pckg_sz)) >= 32'(drvrs));

   // Pointers, occupancy, event pulses and sticky flags (set wins over clear)
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wr_ptr     <= {PTR_W{1'b0}};
         r_rd_ptr     <= {PTR_W{1'b0}};
         r_count      <= {CNT_W{1'b0}};
         r_ovf        <= 1'b0;
         r_udf        <= 1'b0;
         r_bad_id     <= 1'b0;
         r_ovf_sticky <= 1'b0;
         r_udf_sticky <= 1'b0;
      end else begin
         if (w_wr_en) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         end
         if (w_rd_adv) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         r_count      <= w_count_nxt;
         r_ovf        <= w_ovf;
         r_udf        <= w_udf;
         r_bad_id     <= w_bad_id;
         r_ovf_sticky <= w_ovf | (r_ovf_sticky & ~bus.clr_flags);
         r_udf_sticky <= w_udf | (r_udf_sticky & ~bus.clr_flags);
      end
   end

   bus_fifo_mem #(
      .DATA_W (pckg_sz),
      .DEPTH  (depth)
   ) u_mem (
      .clk     (clk),
      .i_we    (w_wr_en),
      .i_waddr (r_wr_ptr),
      .i_wdata (bus.D_push),
      .i_raddr (r_rd_ptr),
      .o_rdata (w_rd_data)
   );

   assign bus.D_pop      = w_empty ? {pckg_sz{1'b0}} : w_rd_data;
   assign bus.pndng      = ~w_empty;
   assign bus.full       = w_full;
   assign bus.count      = r_count;
   assign bus.ovf        = r_ovf;
   assign bus.udf        = r_udf;
   assign bus.bad_id     = r_bad_id;
   assign bus.ovf_sticky = r_ovf_sticky;
   assign bus.udf_sticky = r_udf_sticky;
endmodule

// File: doc/bus_port_fifo.md
Name: bus_port_fifo

Overview:
Per-device source FIFO that sits between a device's driver and the shared bus, one instance per driver port.
- The device side pushes packets of the form {id, dato}.
- The bus side reads the head word combinationally and pops it with a handshake.
- Also tracks occupancy and reports overflow and underflow events.

Parameters:
- pckg_sz, 16: packet width in bits; the top 8 bits are the destination id and the rest is the payload.
- depth, 8: number of entries; a power of two, 2..256.
- DROP_OLDEST, 1: push-when-full policy. 1 = overwrite the oldest entry; 0 = discard the incoming word.
- drvrs, 4: number of bus ports; used only for the id range check.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- push  in  1  device writes D_push this cycle.
- D_push  in  pckg_sz  packet to enqueue.
- pop  in  1  bus consumes the head word this cycle.
- D_pop  out  pckg_sz  head word (first-word fall-through); 0 when empty.
- pndng  out  1  FIFO non-empty.
- full  out  1  count == depth.
- count  out  $clog2(depth+1)  current occupancy.
- ovf  out  1  one-cycle pulse: a push arrived while full without a same-cycle pop.
- udf  out  1  one-cycle pulse: pop while empty.
- bad_id  out  1  one-cycle pulse: accepted push has id >= drvrs; the word is still stored.
- clr_flags  in  1  synchronous clear of the sticky flags.
- ovf_sticky  out  1  set by ovf; cleared by clr_flags.
- udf_sticky  out  1  set by udf; cleared by clr_flags.

Behaviour:
- Reset (reset low, asynchronous) clears:
  - rd_ptr = wr_ptr = 0, count = 0, pndng = 0, full = 0, D_pop = 0;
  - ovf, udf, bad_id = 0; both sticky flags = 0.
  - Storage array contents are not cleared.
  - Reset asserted mid-operation discards all queued words immediately.
- Storage: depth x pckg_sz array with log2(depth)-bit pointers that wrap naturally from depth-1 to 0. count is tracked separately.
- D_pop = mem[rd_ptr] when count > 0, else 0. It is combinational from registered state, so the head is visible in the same cycle pndng is high.
- Latency: a word pushed at edge N is visible on D_pop/pndng after edge N when the FIFO was empty (one-cycle write-to-read).
- Per-edge cases (push, pop, state):
  - push only, not full: write at wr_ptr, wr_ptr++, count++.
  - push only, full, DROP_OLDEST=1: write at wr_ptr, wr_ptr++, rd_ptr++, count unchanged, ovf=1.
  - push only, full, DROP_OLDEST=0: no write, pointers unchanged, ovf=1.
  - pop only, not empty: rd_ptr++, count--.
  - pop only, empty: no change, udf=1.
  - push and pop, not empty (including full): write and read both occur; both pointers advance; count unchanged; no ovf.
  - push and pop, empty: push is accepted (count becomes 1); pop is ignored; udf=1. Bypass is not allowed.
- bad_id is evaluated only when a word is actually written: D_push[pckg_sz-1 -: 8] >= drvrs gives a pulse the next cycle.
- ovf, udf and bad_id are registered and high for exactly one cycle per event.
- Sticky flags:
  - clr_flags clears both sticky flags.
  - If clr_flags and a new event occur in the same cycle, the sticky flag ends set (set wins).
- full and pndng are derived from count. No X on any output after reset.

Decomposition:
- Shared package bus_pkg holds:
  - ID_W = 8;
  - function get_id(pkt), returning the id field;
  - typedef enum for the overflow policy (DROP_NEW, DROP_OLDEST).
- One natural sub-module: bus_fifo_mem, the simple dual-port register array (write port plus asynchronous read port).
- bus_port_fifo holds pointers, count, policy logic and flags.

Test Plan:
- Fill and drain (depth=8): push 8 words 0x0001..0x0008 back-to-back, then pop 8.
  - full=1 after 8th edge, count=8.
  - D_pop sequence 0x0001..0x0008.
  - pndng=0 and D_pop=0 after the last pop.
- Overflow with DROP_OLDEST=1: full FIFO, push 0x0009.
  - ovf pulses once; count stays 8; head becomes 0x0002; last popped word is 0x0009.
  - Same stimulus with DROP_OLDEST=0: head stays 0x0001 and 0x0009 is never read.
- Simultaneous push/pop: with full, push 0x00AA and pop on one edge.
  - No ovf; count=8; 0x00AA is popped 8th.
  - With empty, push 0x00BB and pop on one edge: udf=1, count=1, D_pop=0x00BB.
- Pointer wrap: 20 cycles of alternating push/pop (values 0x0100+i).
  - Every value is popped in order; count never exceeds 1.
- Id check (drvrs=4): push 0x0355 then 0x0455.
  - bad_id pulses only for 0x0455; both words are stored and read back.
- Reset mid-operation and flag clear:
  - count=5, then reset low for 1 ns between edges: count=0, pndng=0, D_pop=0 immediately.
  - Separately, clr_flags in the same cycle as udf: udf_sticky remains 1.
